// File: rtl/lc3_mem_arbiter_if.sv
// Bus bundle between the LC3 core ports, the arbiter and the unified memory.
// The slave view belongs to the arbiter; the master view is the core/memory side.
interface lc3_mem_arbiter_if;
    logic        I_req;
    logic [15:0] I_addr;
    logic [15:0] I_dout;
    logic        I_complete;

    logic        D_req;
    logic        D_rd;
    logic [15:0] D_addr;
    logic [15:0] D_din;
    logic [15:0] D_dout;
    logic        D_complete;

    logic [15:0] mem_addr;
    logic [15:0] mem_din;
    logic        mem_rd;
    logic        mem_wr;
    logic [15:0] mem_dout;
    logic        mem_complete;

    logic        err;

    modport slave (
        input  I_req, I_addr, D_req, D_rd, D_addr, D_din, mem_dout, mem_complete,
        output I_dout, I_complete, D_dout, D_complete,
        output mem_addr, mem_din, mem_rd, mem_wr, err
    );

    modport master (
        output I_req, I_addr, D_req, D_rd, D_addr, D_din, mem_dout, mem_complete,
        input  I_dout, I_complete, D_dout, D_complete,
        input  mem_addr, mem_din, mem_rd, mem_wr, err
    );
endinterface

// File: rtl/lc3_mem_arbiter.sv
// Two-port-to-one memory arbiter: shares one 64K x 16 memory between the
// instruction-fetch port and the data port, alternating fairly under
// contention, with a watchdog that aborts accesses the memory never finishes.
module lc3_mem_arbiter #(
    parameter int          TIMEOUT  = 16,
    parameter logic [15:0] ERR_DATA = 16'hDEAD
) (
    input  logic              clock,
    input  logic              reset,
    lc3_mem_arbiter_if.slave  bus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    localparam logic [7:0] COUNT_LIMIT = 8'(TIMEOUT - 1);

    logic [1:0]  r_state;
    logic        r_grant;
    logic        r_lastGrant;
    logic        r_isRead;
    logic [7:0]  r_count;
    logic [15:0] r_memAddr;
    logic [15:0] r_memDin;
    logic        r_memRd;
    logic        r_memWr;
    logic [15:0] r_IDout;
    logic [15:0] r_DDout;
    logic        r_err;

    logic        w_anyReq;
    logic        w_nextGrant;
    logic        w_nextIsRead;

    // Pick the port to serve: a lone requester wins, a tie goes to the port not served last.
    always_comb begin
        w_anyReq     = bus.I_req | bus.D_req;
        w_nextGrant  = PORT_I;
        if (bus.I_req && bus.D_req) begin
            w_nextGrant = (r_lastGrant == PORT_I) ? PORT_D : PORT_I;
        end else if (bus.D_req) begin
            w_nextGrant = PORT_D;
        end
        w_nextIsRead = (w_nextGrant == PORT_I) ? 1'b1 : bus.D_rd;
    end

    // Access sequencer: latch the granted request, strobe memory, wait with watchdog, respond.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_grant     <= PORT_I;
            r_lastGrant <= PORT_D;
            r_isRead    <= 1'b0;
            r_count     <= 8'd0;
            r_memAddr   <= 16'd0;
            r_memDin    <= 16'd0;
            r_memRd     <= 1'b0;
            r_memWr     <= 1'b0;
            r_IDout     <= 16'd0;
            r_DDout     <= 16'd0;
            r_err       <= 1'b0;
        end else begin
            r_memRd <= 1'b0;
            r_memWr <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_anyReq) begin
                        r_grant  <= w_nextGrant;
                        r_isRead <= w_nextIsRead;
                        r_memRd  <= w_nextIsRead;
                        r_memWr  <= ~w_nextIsRead;
                        if (w_nextGrant == PORT_D) begin
                            r_memAddr <= bus.D_addr;
                            r_memDin  <= bus.D_din;
                        end else begin
                            r_memAddr <= bus.I_addr;
                        end
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_count <= 8'd0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.mem_complete) begin
                        if (r_isRead) begin
                            if (r_grant == PORT_D) r_DDout <= bus.mem_dout;
                            else                   r_IDout <= bus.mem_dout;
                        end
                        r_state <= S_RESP;
                    end else if (r_count == COUNT_LIMIT) begin
                        if (r_isRead) begin
                            if (r_grant == PORT_D) r_DDout <= ERR_DATA;
                            else                   r_IDout <= ERR_DATA;
                        end
                        r_err   <= 1'b1;
                        r_state <= S_RESP;
                    end else begin
                        r_count <= r_count + 8'd1;
                    end
                end
                S_RESP: begin
                    r_lastGrant <= r_grant;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Complete pulses are decoded from the RESP state so only the granted port ever pulses.
    always_comb begin
        bus.I_complete = (r_state == S_RESP) && (r_grant == PORT_I);
        bus.D_complete = (r_state == S_RESP) && (r_grant == PORT_D);
        bus.I_dout     = r_IDout;
        bus.D_dout     = r_DDout;
        bus.mem_addr   = r_memAddr;
        bus.mem_din    = r_memDin;
        bus.mem_rd     = r_memRd;
        bus.mem_wr     = r_memWr;
        bus.err        = r_err;
    end

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// Scoreboard bench for lc3_mem_arbiter: stimulus pushes expected responses,
// an independent monitor pops and compares on every complete pulse.
module tb_lc3_mem_arbiter;

    localparam int TIMEOUT = 16;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    lc3_mem_arbiter_if bus();

    lc3_mem_arbiter #(
        .TIMEOUT  (TIMEOUT),
        .ERR_DATA (16'hDEAD)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic        isD;
        logic        isWrite;
        logic [15:0] data;
        logic        err;
    } expT;

    expT         expQ[$];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] memModel [0:65535];
    int          memDelay = 0;
    logic        memStuck = 1'b0;
    logic [15:0] expIdout = 16'h0;
    logic [15:0] expDdout = 16'h0;

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    // Memory model: sees a strobe mid-ISSUE, answers after memDelay extra WAIT cycles
    initial begin : memModelProc
        logic [15:0] a;
        logic        rd;
        bus.mem_complete = 1'b0;
        bus.mem_dout     = 16'hBAD0;
        forever begin
            @(negedge clock);
            if (!reset && (bus.mem_rd || bus.mem_wr)) begin
                a  = bus.mem_addr;
                rd = bus.mem_rd;
                if (bus.mem_wr) memModel[a] = bus.mem_din;
                @(posedge clock);
                repeat (memDelay) @(posedge clock);
                if (!memStuck) begin
                    #1;
                    bus.mem_complete = 1'b1;
                    bus.mem_dout     = rd ? memModel[a] : 16'hBAD1;
                    @(posedge clock);
                    #1;
                    bus.mem_complete = 1'b0;
                    bus.mem_dout     = 16'hBAD0;
                end
            end
        end
    end

    // Monitor: pops the scoreboard on every complete pulse and checks port, data and err
    initial begin : monitorProc
        expT         e;
        logic [15:0] want;
        forever begin
            @(negedge clock);
            if (!reset && (bus.I_complete || bus.D_complete)) begin
                checkOutput("exclusiveComplete", {15'b0, bus.I_complete & bus.D_complete}, 16'h0);
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpectedComplete actual I=%b D=%b expected none", bus.I_complete, bus.D_complete);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("grantPort", {15'b0, bus.D_complete}, {15'b0, e.isD});
                    if (e.isD) begin
                        want = e.isWrite ? expDdout : e.data;
                        checkOutput("D_dout", bus.D_dout, want);
                        checkOutput("I_doutHeld", bus.I_dout, expIdout);
                        expDdout = want;
                    end else begin
                        checkOutput("I_dout", bus.I_dout, e.data);
                        checkOutput("D_doutHeld", bus.D_dout, expDdout);
                        expIdout = e.data;
                    end
                    checkOutput("err", {15'b0, bus.err}, {15'b0, e.err});
                end
            end
        end
    end

    // Global time limit so the bench can never hang
    initial begin : watchdogProc
        #400000;
        $display("[TB] FAIL globalTimeout actual=running expected=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

    task automatic checkResetOutputs();
        checkOutput("rst_mem_addr", bus.mem_addr, 16'h0);
        checkOutput("rst_mem_din", bus.mem_din, 16'h0);
        checkOutput("rst_mem_rd", {15'b0, bus.mem_rd}, 16'h0);
        checkOutput("rst_mem_wr", {15'b0, bus.mem_wr}, 16'h0);
        checkOutput("rst_I_dout", bus.I_dout, 16'h0);
        checkOutput("rst_D_dout", bus.D_dout, 16'h0);
        checkOutput("rst_I_complete", {15'b0, bus.I_complete}, 16'h0);
        checkOutput("rst_D_complete", {15'b0, bus.D_complete}, 16'h0);
        checkOutput("rst_err", {15'b0, bus.err}, 16'h0);
    endtask

    // One access on one port: push expectation, drive, check strobes and latency
    task automatic applyStimulus(input logic isD, input logic rd, input logic [15:0] addr,
                                 input logic [15:0] din, input logic [15:0] expData,
                                 input logic expErr, input int expLat);
        expT e;
        int  cyc;
        bit  done;
        e.isD     = isD;
        e.isWrite = ~rd;
        e.data    = expData;
        e.err     = expErr;
        expQ.push_back(e);
        @(posedge clock);
        #1;
        if (isD) begin
            bus.D_req  = 1'b1;
            bus.D_rd   = rd;
            bus.D_addr = addr;
            bus.D_din  = din;
        end else begin
            bus.I_req  = 1'b1;
            bus.I_addr = addr;
        end
        cyc  = 0;
        done = 1'b0;
        while (!done && cyc < 300) begin
            @(negedge clock);
            cyc++;
            if (cyc == 2) begin
                checkOutput("issue_mem_rd", {15'b0, bus.mem_rd}, {15'b0, rd});
                checkOutput("issue_mem_wr", {15'b0, bus.mem_wr}, {15'b0, ~rd});
                checkOutput("issue_mem_addr", bus.mem_addr, addr);
                if (!rd) checkOutput("issue_mem_din", bus.mem_din, din);
            end
            if (cyc == 3) begin
                checkOutput("wait_strobes", {14'b0, bus.mem_rd, bus.mem_wr}, 16'h0);
            end
            if (bus.I_complete || bus.D_complete) done = 1'b1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL completeWait actual=none expected=complete within 300 cycles");
        end else begin
            checkOutput("latency", 16'(cyc), 16'(expLat));
        end
        @(posedge clock);
        #1;
        if (isD) bus.D_req = 1'b0;
        else     bus.I_req = 1'b0;
    endtask

    initial begin : stimulusProc
        int   cyc;
        int   lastCyc;
        int   got;
        expT  e;
        reset      = 1'b1;
        bus.I_req  = 1'b0;
        bus.I_addr = 16'h0;
        bus.D_req  = 1'b0;
        bus.D_rd   = 1'b0;
        bus.D_addr = 16'h0;
        bus.D_din  = 16'h0;
        memModel[16'h3000] = 16'h1234;
        memModel[16'h3004] = 16'hABCD;
        memModel[16'h300A] = 16'h0000;
        repeat (3) @(posedge clock);
        #1;
        checkResetOutputs();
        @(negedge clock);
        reset = 1'b0;

        $display("[TB] single fetch");
        applyStimulus(1'b0, 1'b1, 16'h3000, 16'h0, 16'h1234, 1'b0, 4);

        $display("[TB] data write then read back");
        applyStimulus(1'b1, 1'b0, 16'h300A, 16'h0002, 16'h0, 1'b0, 4);
        applyStimulus(1'b1, 1'b1, 16'h300A, 16'h0, 16'h0002, 1'b0, 4);

        $display("[TB] slow memory, 5 extra wait cycles");
        memDelay = 5;
        applyStimulus(1'b0, 1'b1, 16'h3004, 16'h0, 16'hABCD, 1'b0, 9);
        memDelay = 0;

        $display("[TB] timeout on data read");
        memStuck = 1'b1;
        applyStimulus(1'b1, 1'b1, 16'h3000, 16'h0, 16'hDEAD, 1'b1, 3 + TIMEOUT);
        memStuck = 1'b0;

        $display("[TB] err stays set after timeout");
        applyStimulus(1'b0, 1'b1, 16'h3000, 16'h0, 16'h1234, 1'b1, 4);
        applyStimulus(1'b1, 1'b0, 16'h3010, 16'h5555, 16'h0, 1'b1, 4);

        $display("[TB] reset in the middle of WAIT");
        memStuck = 1'b1;
        @(posedge clock);
        #1;
        bus.D_req  = 1'b1;
        bus.D_rd   = 1'b1;
        bus.D_addr = 16'h300A;
        repeat (3) @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        checkResetOutputs();
        bus.D_req = 1'b0;
        expIdout  = 16'h0;
        expDdout  = 16'h0;
        @(negedge clock);
        reset    = 1'b0;
        memStuck = 1'b0;
        repeat (10) @(posedge clock);

        $display("[TB] contention for 8 accesses");
        for (int k = 0; k < 8; k++) begin
            e.isD     = (k % 2 == 1);
            e.isWrite = 1'b0;
            e.data    = e.isD ? 16'h0002 : 16'h1234;
            e.err     = 1'b0;
            expQ.push_back(e);
        end
        @(posedge clock);
        #1;
        bus.I_addr = 16'h3000;
        bus.D_addr = 16'h300A;
        bus.D_rd   = 1'b1;
        bus.I_req  = 1'b1;
        bus.D_req  = 1'b1;
        cyc     = 0;
        lastCyc = 0;
        got     = 0;
        while (got < 8 && cyc < 200) begin
            @(negedge clock);
            cyc++;
            if (bus.I_complete || bus.D_complete) begin
                got++;
                checkOutput("contentionSpacing", 16'(cyc - lastCyc), 16'd4);
                lastCyc = cyc;
            end
        end
        @(posedge clock);
        #1;
        bus.I_req = 1'b0;
        bus.D_req = 1'b0;
        checkOutput("contentionCount", 16'(got), 16'd8);
        repeat (6) @(posedge clock);
        checkOutput("scoreboardEmpty", 16'(expQ.size()), 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
